router_1x1: RTL and testbench
=============================

Name: router_1x1

Overview:
- Single-input, single-output store-and-forward packet router with a CSR port.
- Receives a byte-serial packet, buffers and validates it (length, checksum), then retransmits it byte-serially unchanged, or drops it and flags an error.
- Sits between an upstream byte source and a downstream byte sink.
- CSR side gives software control and statistics counters.

Parameters:
- MAX_PKT, 64, buffer depth in bytes; largest accepted packet.
- MIN_PKT, 11, smallest legal packet length (10-byte header + 1 payload byte).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- dut_inp  in  8  input packet byte
- inp_valid  in  1  dut_inp holds a valid byte this cycle; packet bytes are contiguous
- dut_outp  out  8  output packet byte
- outp_valid  out  1  dut_outp holds a valid byte this cycle
- busy  out  1  router cannot accept a new packet
- error  out  1  one-cycle pulse: packet dropped
- wr  in  1  CSR write strobe
- rd  in  1  CSR read strobe
- addr  in  8  CSR byte address
- wdata  in  32  CSR write data
- rdata  out  32  CSR read data

Behaviour:
- Packet format, in byte order:
  - byte0 SA
  - byte1 DA
  - bytes2-5 LEN: total bytes including header, MSB first
  - bytes6-9 CRC: 32-bit sum mod 2^32 of payload bytes, MSB first
  - bytes10.. payload
- Packet ends at the first sampled inp_valid=0 after a valid byte.
- Reset values: dut_outp=0, outp_valid=0, busy=0, error=0, rdata=0, all counters 0, CTRL=1. The FSM returns to IDLE and the buffer is discarded, including when reset asserts mid-packet.
- FSM states: IDLE, RECV, CHECK, SEND.
- IDLE: inp_valid=1 with CTRL.en=1 -> store byte, go to RECV. With CTRL.en=0, input is ignored.
- RECV: each edge with inp_valid=1 stores one byte. inp_valid=0 -> CHECK.
  - Byte count exceeding MAX_PKT sets an overflow flag; further bytes are discarded.
- CHECK (one cycle, busy=1): packet is good if all of the following hold:
  - no overflow
  - received count == LEN
  - MIN_PKT <= LEN <= MAX_PKT
  - payload sum == CRC
- CHECK, good packet -> SEND.
- CHECK, bad packet -> error=1 for exactly one cycle, buffer discarded, back to IDLE.
- SEND: outp_valid=1 and one byte per cycle, byte0 first, for LEN cycles. Then outp_valid=0, dut_outp=0, -> IDLE.
- Latency: first output byte is registered on the edge after CHECK, i.e. 2 edges after the edge that sampled inp_valid=0.
- busy=1 in CHECK and SEND; busy=0 in IDLE and RECV.
- inp_valid=1 while busy: bytes ignored; error pulses once per such burst; DROP_CNT increments by 1.
- CSR write: register updated on the edge with wr=1. Only CTRL is writable.
  - Writing 1 to CLR_CNT (bit1) clears all counters; the bit self-clears.
- CSR read: rdata is registered on the edge with rd=1 and valid the following cycle. rdata holds its value until the next read.
- Unmapped address reads 0; unmapped writes are ignored.
- wr and rd together: the write takes effect, and the read returns the pre-write value.
- CSR map:
  - 0x00 CTRL: bit0 en (reset 1), bit1 clr_cnt
  - 0x04 RX_PKT_CNT
  - 0x08 TX_PKT_CNT
  - 0x0C DROP_CNT
  - 0x10 CRC_ERR_CNT
  - 0x14 LEN_ERR_CNT
- Counter updates:
  - RX increments on entry to CHECK.
  - TX increments on completion of SEND.
  - DROP increments on every dropped packet or burst.
  - CRC and LEN counters increment per failure type; length failure takes precedence and CRC is then not counted.
- Counters saturate at 0xFFFFFFFF.

Decomposition:
- Package router_pkg:
  - FSM state enum
  - CSR address constants
  - header offsets (SA=0, DA=1, LEN=2, CRC=6, PAYLOAD=10)
  - CTRL bit indices
- Sub-module router_csr holds CTRL, counters and read mux. It is driven by event pulses from the datapath FSM.

Test Plan:
- Reset with reset=0 mid-packet -> all outputs 0, CTRL read = 0x1, all counters 0, no output bytes after release.
- Good packet SA=0x11, DA=0x22, LEN=12, payload 0x05,0x06, CRC=0x0000000B -> the 12 identical bytes appear on dut_outp 2 edges after inp_valid falls; busy high through SEND; RX=1, TX=1.
- Same packet with CRC=0x0000000C -> no outp_valid; error pulses 1 cycle after CHECK entry; CRC_ERR=1, DROP=1.
- LEN=12 but 13 bytes sent; separately, a 70-byte stream with MAX_PKT=64 -> error, LEN_ERR increments each time, no output.
- Bytes driven during SEND -> ignored, output unaltered, error pulses once, DROP+1.
- CSR: write CTRL=0, then send a good packet -> no output, RX unchanged. Write CTRL=0x3 -> counters read 0, CTRL reads 0x1. Read 0x40 -> 0.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for router_1x1
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_SEND
  } state_t;

  localparam logic [7:0] CSR_CTRL = 8'h00;
  localparam logic [7:0] CSR_RX   = 8'h04;
  localparam logic [7:0] CSR_TX   = 8'h08;
  localparam logic [7:0] CSR_DROP = 8'h0C;
  localparam logic [7:0] CSR_CRC  = 8'h10;
  localparam logic [7:0] CSR_LEN  = 8'h14;

  // Header layout, each field following the previous one
  localparam int OFF_SA      = 0;
  localparam int OFF_DA      = OFF_SA + 1;
  localparam int OFF_LEN     = OFF_DA + 1;
  localparam int OFF_CRC     = OFF_LEN + 4;
  localparam int OFF_PAYLOAD = OFF_CRC + 4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, v} + {31'b0, n};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/router_csr.sv
// rtl/router_csr.sv - control register, saturating statistics counters and read mux
module router_csr
  import router_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_ev_rx,
  input  logic        i_ev_tx,
  input  logic        i_ev_drop_pkt,
  input  logic        i_ev_drop_burst,
  input  logic        i_ev_crc,
  input  logic        i_ev_len,
  output logic        o_en,
  output logic [31:0] o_rdata
);

  logic        r_en;
  logic [31:0] r_rx, r_tx, r_drop, r_crc, r_len, r_rdata;
  logic        w_ctrl_wr, w_clr;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  assign w_ctrl_wr      = i_wr && (i_addr == CSR_CTRL);
  assign w_clr          = w_ctrl_wr && i_wdata[CTRL_CLR];
  assign w_unused_wdata = ^i_wdata[31:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en   <= 1'b1;
      r_rx   <= '0;
      r_tx   <= '0;
      r_drop <= '0;
      r_crc  <= '0;
      r_len  <= '0;
    end else begin
      if (w_ctrl_wr) r_en <= i_wdata[CTRL_EN];
      // Clear wins over any event landing in the same cycle
      if (w_clr) begin
        r_rx   <= '0;
        r_tx   <= '0;
        r_drop <= '0;
        r_crc  <= '0;
        r_len  <= '0;
      end else begin
        r_rx   <= sat_add(r_rx, {1'b0, i_ev_rx});
        r_tx   <= sat_add(r_tx, {1'b0, i_ev_tx});
        r_drop <= sat_add(r_drop, {1'b0, i_ev_drop_pkt} + {1'b0, i_ev_drop_burst});
        r_crc  <= sat_add(r_crc, {1'b0, i_ev_crc});
        r_len  <= sat_add(r_len, {1'b0, i_ev_len});
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_addr)
      CSR_CTRL: w_rd_mux = {31'b0, r_en};
      CSR_RX:   w_rd_mux = r_rx;
      CSR_TX:   w_rd_mux = r_tx;
      CSR_DROP: w_rd_mux = r_drop;
      CSR_CRC:  w_rd_mux = r_crc;
      CSR_LEN:  w_rd_mux = r_len;
      default:  w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else if (i_rd) r_rdata <= w_rd_mux;
  end

  assign o_en    = r_en;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/router_1x1.sv
// rtl/router_1x1.sv - store-and-forward byte-serial packet router with length/checksum validation
module router_1x1
  import router_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter int MIN_PKT = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  dut_inp,
  input  logic        inp_valid,
  output logic [7:0]  dut_outp,
  output logic        outp_valid,
  output logic        busy,
  output logic        error,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int AW = $clog2(MAX_PKT);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_buf [MAX_PKT];
  logic [CW-1:0] r_cnt, r_idx;
  logic [31:0]   r_sum;
  logic          r_ovf, r_burst, r_error, r_outp_valid;
  logic [7:0]    r_outp;

  logic [31:0]   w_len, w_crc;
  logic          w_len_bad, w_crc_bad, w_good, w_full, w_busy, w_en;
  logic          w_store, w_buf_we, w_burst_start, w_send_done;
  logic [AW-1:0] w_buf_addr;
  logic          w_ev_rx, w_ev_tx, w_ev_crc, w_ev_len, w_drop_pkt;

  assign w_len = {r_buf[AW'(OFF_LEN)], r_buf[AW'(OFF_LEN + 1)],
                  r_buf[AW'(OFF_LEN + 2)], r_buf[AW'(OFF_LEN + 3)]};
  assign w_crc = {r_buf[AW'(OFF_CRC)], r_buf[AW'(OFF_CRC + 1)],
                  r_buf[AW'(OFF_CRC + 2)], r_buf[AW'(OFF_CRC + 3)]};

  assign w_full      = (r_cnt == CW'(MAX_PKT));
  assign w_len_bad   = r_ovf || (32'(r_cnt) != w_len) ||
                       (w_len < 32'(MIN_PKT)) || (w_len > 32'(MAX_PKT));
  assign w_crc_bad   = (r_sum != w_crc);
  assign w_good      = !w_len_bad && !w_crc_bad;
  assign w_busy      = (r_state == ST_CHECK) || (r_state == ST_SEND);
  // One drop/error per contiguous run of input bytes arriving while busy
  assign w_burst_start = w_busy && inp_valid && !r_burst;
  assign w_send_done = (32'(r_idx) == w_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_ev_rx     = 1'b0;
    w_ev_tx     = 1'b0;
    w_ev_crc    = 1'b0;
    w_ev_len    = 1'b0;
    w_drop_pkt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A burst that began while busy is not mistaken for a new packet
        if (inp_valid && w_en && !r_burst) begin
          w_store     = 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (inp_valid) begin
          w_store = 1'b1;
        end else begin
          w_ev_rx     = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_good) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_drop_pkt  = 1'b1;
          w_ev_len    = w_len_bad;
          w_ev_crc    = !w_len_bad;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_send_done) begin
          w_ev_tx     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_buf_addr = (r_state == ST_IDLE) ? '0 : r_cnt[AW-1:0];
    w_buf_we   = w_store && ((r_state == ST_IDLE) || !w_full);
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_buf_addr] <= dut_inp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_burst      <= 1'b0;
      r_error      <= 1'b0;
      r_outp       <= '0;
      r_outp_valid <= 1'b0;
    end else begin
      r_error <= w_drop_pkt | w_burst_start;
      if (!inp_valid)         r_burst <= 1'b0;
      else if (w_burst_start) r_burst <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_store) begin
            r_cnt <= CW'(1);
            r_ovf <= 1'b0;
            r_sum <= '0;
          end
        end
        ST_RECV: begin
          if (w_store) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
              if (r_cnt >= CW'(OFF_PAYLOAD)) r_sum <= r_sum + {24'b0, dut_inp};
            end
          end
        end
        ST_CHECK: begin
          if (w_good) begin
            r_outp       <= r_buf[AW'(OFF_SA)];
            r_outp_valid <= 1'b1;
            r_idx        <= CW'(1);
          end
        end
        ST_SEND: begin
          if (w_send_done) begin
            r_outp       <= '0;
            r_outp_valid <= 1'b0;
          end else begin
            r_outp <= r_buf[r_idx[AW-1:0]];
            r_idx  <= r_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  router_csr u_csr (
    .i_clk           (clk),
    .i_rst_n         (reset),
    .i_wr            (wr),
    .i_rd            (rd),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .i_ev_rx         (w_ev_rx),
    .i_ev_tx         (w_ev_tx),
    .i_ev_drop_pkt   (w_drop_pkt),
    .i_ev_drop_burst (w_burst_start),
    .i_ev_crc        (w_ev_crc),
    .i_ev_len        (w_ev_len),
    .o_en            (w_en),
    .o_rdata         (rdata)
  );

  assign dut_outp   = r_outp;
  assign outp_valid = r_outp_valid;
  assign busy       = w_busy;
  assign error      = r_error;

endmodule

// File: tb/tb_router_1x1.sv
// tb/tb_router_1x1.sv - self-checking bench for router_1x1
module tb_router_1x1;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dut_inp = '0;
  logic        inp_valid = 1'b0;
  logic [7:0]  dut_outp;
  logic        outp_valid, busy, error;
  logic        wr = 1'b0, rd = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  router_1x1 dut (
    .clk(clk), .reset(reset), .dut_inp(dut_inp), .inp_valid(inp_valid),
    .dut_outp(dut_outp), .outp_valid(outp_valid), .busy(busy), .error(error),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  localparam int K_GOOD = 0;
  localparam int K_LEN  = 1;
  localparam int K_CRC  = 2;
  localparam int NV     = 12;

  typedef struct {
    int          total;
    logic [31:0] len;
    logic [31:0] crc_delta;
    logic [7:0]  base;
    int          kind;
  } vec_t;

  vec_t        vecs [NV];
  int          total_n = 0;
  int          bad_n = 0;
  int          err_cycles = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  pkt_q [$];
  logic [7:0]  mon_e;
  logic [31:0] m_rx = 0, m_tx = 0, m_drop = 0, m_crc = 0, m_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (error === 1'b1) err_cycles++;
    if (outp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(outp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_byte", {24'b0, dut_outp}, {24'b0, mon_e});
      end
    end
  end

  task automatic build(input vec_t v);
    logic [31:0] s;
    logic [31:0] c;
    logic [7:0]  b;
    s = 0;
    pkt_q.delete();
    for (int i = 10; i < v.total; i++) begin
      b = v.base + 8'(i - 10);
      s = s + {24'b0, b};
    end
    c = s + v.crc_delta;
    pkt_q.push_back(8'h11);
    pkt_q.push_back(8'h22);
    for (int k = 3; k >= 0; k--) pkt_q.push_back(v.len[k*8 +: 8]);
    for (int k = 3; k >= 0; k--) pkt_q.push_back(c[k*8 +: 8]);
    for (int i = 10; i < v.total; i++) pkt_q.push_back(v.base + 8'(i - 10));
  endtask

  task automatic send_bytes();
    foreach (pkt_q[i]) begin
      @(posedge clk); #1;
      dut_inp = pkt_q[i];
      inp_valid = 1'b1;
    end
    @(posedge clk); #1;
    inp_valid = 1'b0;
    dut_inp = '0;
  endtask

  task automatic expect_pkt(input int kind);
    m_rx++;
    if (kind == K_GOOD) begin
      m_tx++;
      foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
    end else begin
      m_drop++;
      if (kind == K_LEN) m_len++;
      else m_crc++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((busy !== 1'b0 || outp_valid !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= 200), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic check_cnts(input string tag);
    logic [31:0] d;
    csr_rd(CSR_RX, d);   check($sformatf("%s_rx", tag), d, m_rx);
    csr_rd(CSR_TX, d);   check($sformatf("%s_tx", tag), d, m_tx);
    csr_rd(CSR_DROP, d); check($sformatf("%s_drop", tag), d, m_drop);
    csr_rd(CSR_CRC, d);  check($sformatf("%s_crcerr", tag), d, m_crc);
    csr_rd(CSR_LEN, d);  check($sformatf("%s_lenerr", tag), d, m_len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int e0;
    vec_t vb;

    vecs[0]  = '{12, 32'd12, 32'd0,     8'h05, K_GOOD};
    vecs[1]  = '{12, 32'd12, 32'd1,     8'h05, K_CRC};
    vecs[2]  = '{13, 32'd12, 32'd0,     8'h05, K_LEN};
    vecs[3]  = '{70, 32'd70, 32'd0,     8'h01, K_LEN};
    vecs[4]  = '{11, 32'd11, 32'd0,     8'h80, K_GOOD};
    vecs[5]  = '{64, 32'd64, 32'd0,     8'hF0, K_GOOD};
    vecs[6]  = '{10, 32'd10, 32'd0,     8'h00, K_LEN};
    vecs[7]  = '{65, 32'd65, 32'd0,     8'h10, K_LEN};
    vecs[8]  = '{13, 32'd12, 32'd5,     8'h33, K_LEN};
    vecs[9]  = '{30, 32'd30, 32'd0,     8'hA5, K_GOOD};
    vecs[10] = '{12, 32'd20, 32'd0,     8'h07, K_LEN};
    vecs[11] = '{20, 32'd20, 32'h100,   8'h40, K_CRC};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outp", {24'b0, dut_outp}, 32'd0);
    check("rst_valid", 32'(outp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    csr_rd(CSR_CTRL, d);
    check("ctrl_after_rst", d, 32'd1);

    // Reset asserted mid-packet discards it
    e0 = err_cycles;
    build(vecs[0]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      dut_inp = pkt_q[i];
      inp_valid = 1'b1;
    end
    #1 reset = 1'b0;
    #1;
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(outp_valid), 32'd0);
    @(posedge clk); #1;
    inp_valid = 1'b0;
    dut_inp = '0;
    reset = 1'b1;
    csr_rd(CSR_CTRL, d);
    check("midrst_ctrl", d, 32'd1);
    repeat (20) @(negedge clk);
    check("midrst_err", 32'(err_cycles - e0), 32'd0);
    check_cnts("midrst");

    // Good packet, first byte two edges after inp_valid falls
    build(vecs[0]);
    expect_pkt(K_GOOD);
    send_bytes();
    @(negedge clk);
    check("lat_recv_busy", 32'(busy), 32'd0);
    check("lat_recv_valid", 32'(outp_valid), 32'd0);
    @(negedge clk);
    check("lat_check_busy", 32'(busy), 32'd1);
    check("lat_check_valid", 32'(outp_valid), 32'd0);
    @(negedge clk);
    check("lat_send_valid", 32'(outp_valid), 32'd1);
    check("lat_send_byte0", {24'b0, dut_outp}, 32'h11);
    check("lat_send_busy", 32'(busy), 32'd1);
    wait_idle();
    check("lat_outp_idle", {24'b0, dut_outp}, 32'd0);
    check_cnts("good");

    // Bad checksum: error pulse one cycle after CHECK entry
    build(vecs[1]);
    expect_pkt(K_CRC);
    e0 = err_cycles;
    send_bytes();
    @(negedge clk);
    check("crc_err_recv", 32'(error), 32'd0);
    @(negedge clk);
    check("crc_err_check", 32'(error), 32'd0);
    @(negedge clk);
    check("crc_err_pulse", 32'(error), 32'd1);
    check("crc_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    check("crc_err_end", 32'(error), 32'd0);
    wait_idle();
    check("crc_err_cnt", 32'(err_cycles - e0), 32'd1);
    check_cnts("crcbad");

    // Table of packets
    for (int v = 0; v < NV; v++) begin
      build(vecs[v]);
      expect_pkt(vecs[v].kind);
      e0 = err_cycles;
      send_bytes();
      wait_idle();
      check($sformatf("vec%0d_err", v), 32'(err_cycles - e0),
            (vecs[v].kind == K_GOOD) ? 32'd0 : 32'd1);
      check_cnts($sformatf("vec%0d", v));
    end

    // Input burst while sending is ignored and dropped once
    vb = '{20, 32'd20, 32'd0, 8'h61, K_GOOD};
    build(vb);
    expect_pkt(K_GOOD);
    m_drop++;
    e0 = err_cycles;
    send_bytes();
    repeat (3) @(posedge clk);
    #1;
    inp_valid = 1'b1;
    dut_inp = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    inp_valid = 1'b0;
    dut_inp = '0;
    wait_idle();
    check("burst_err", 32'(err_cycles - e0), 32'd1);
    check_cnts("burst");

    // Disabled router ignores input
    csr_wr(CSR_CTRL, 32'd0);
    csr_rd(CSR_CTRL, d);
    check("ctrl_dis", d, 32'd0);
    build(vecs[4]);
    e0 = err_cycles;
    send_bytes();
    wait_idle();
    check("dis_err", 32'(err_cycles - e0), 32'd0);
    check_cnts("dis");

    // Simultaneous write and read returns the pre-write value
    @(posedge clk); #1;
    wr = 1'b1; rd = 1'b1; addr = CSR_CTRL; wdata = 32'd1;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    check("wr_rd_prewrite", rdata, 32'd0);
    csr_rd(CSR_CTRL, d);
    check("wr_rd_post", d, 32'd1);

    // Counter clear self-clears, unmapped space reads zero and ignores writes
    csr_wr(CSR_CTRL, 32'd3);
    m_rx = 0; m_tx = 0; m_drop = 0; m_crc = 0; m_len = 0;
    check_cnts("clr");
    csr_rd(CSR_CTRL, d);
    check("clr_ctrl", d, 32'd1);
    csr_rd(8'h40, d);
    check("unmapped_rd", d, 32'd0);
    csr_wr(8'h40, 32'd0);
    csr_rd(CSR_CTRL, d);
    check("unmapped_wr", d, 32'd1);

    build(vecs[4]);
    expect_pkt(K_GOOD);
    send_bytes();
    wait_idle();
    check_cnts("after_clr");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
